// File: rtl/shift_unit_pkg.sv
// Shared definitions for the sequential shift unit: op-code constants,
// FSM state type and the op-support decode.
// Build option: SHIFT_ROTATE_EN enables the ROR/ROL operations.
package shift_unit_pkg;

  localparam logic [3:0] OP_SHR  = 4'b1000;
  localparam logic [3:0] OP_SHRA = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_ROR  = 4'b1011;
  localparam logic [3:0] OP_ROL  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for op codes this build can execute; everything else is flagged illegal.
  function automatic logic op_supported(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_SHR, OP_SHRA, OP_SHL: ok = 1'b1;
`ifdef SHIFT_ROTATE_EN
      OP_ROR, OP_ROL:          ok = 1'b1;
`endif
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/shift_seq_unit_step.sv
// Combinational single-step shifter: moves value by 0..STEP positions
// according to op. Rotate paths exist only when SHIFT_ROTATE_EN is defined.
module shift_step
  import shift_unit_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int AW    = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    amount,
  output logic [WIDTH-1:0] shifted
);

`ifdef SHIFT_ROTATE_EN
  logic [2*WIDTH-1:0] rot;
`endif

  // Select the shifted value for the requested operation.
  always_comb begin
    shifted = value;
`ifdef SHIFT_ROTATE_EN
    rot = '0;
`endif
    case (op)
      OP_SHR:  shifted = value >> amount;
      OP_SHRA: shifted = $signed(value) >>> amount;
      OP_SHL:  shifted = value << amount;
`ifdef SHIFT_ROTATE_EN
      // Doubling the word turns a rotate into a plain shift of one window.
      OP_ROR: begin
        rot     = {value, value} >> amount;
        shifted = rot[WIDTH-1:0];
      end
      OP_ROL: begin
        rot     = {value, value} << amount;
        shifted = rot[2*WIDTH-1:WIDTH];
      end
`endif
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shifter: captures an operation on start, shifts up to STEP
// positions per RUN cycle and reports completion with a one-cycle done.
// Build option: SHIFT_ROTATE_EN enables ROR/ROL; without it they are illegal.
module shift_seq_unit
  import shift_unit_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int AW = $clog2(STEP) + 1;

  state_t           state, state_next;
  logic [WIDTH-1:0] work, work_next;
  logic [3:0]       op_q, op_next;
  logic [SHW-1:0]   remaining, rem_next;
  logic [WIDTH-1:0] result_q, result_next;
  logic             illegal_q, illegal_next;

  logic [AW-1:0]    step_amt;
  logic [SHW-1:0]   rem_after;
  logic [WIDTH-1:0] work_shifted;

  // Per-cycle step is min(STEP, remaining); compared one bit wider since STEP may equal WIDTH.
  always_comb begin
    if ({1'b0, remaining} >= (SHW+1)'(STEP)) begin
      step_amt = AW'(STEP);
    end else begin
      step_amt = AW'(remaining);
    end
    rem_after = remaining - SHW'(step_amt);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value   (work),
    .op      (op_q),
    .amount  (step_amt),
    .shifted (work_shifted)
  );

  // State and datapath registers; clear aborts any operation immediately.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= ST_IDLE;
      work      <= '0;
      op_q      <= '0;
      remaining <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_next;
      work      <= work_next;
      op_q      <= op_next;
      remaining <= rem_next;
      result_q  <= result_next;
      illegal_q <= illegal_next;
    end
  end

  // Next-state and datapath updates; result changes only on entry to DONE.
  always_comb begin
    state_next   = state;
    work_next    = work;
    op_next      = op_q;
    rem_next     = remaining;
    result_next  = result_q;
    illegal_next = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (start) begin
          if (op_supported(op)) begin
            work_next = operand;
            op_next   = op;
            rem_next  = shamt;
            if (shamt == '0) begin
              state_next  = ST_DONE;
              result_next = operand;
            end else begin
              state_next = ST_RUN;
            end
          end else begin
            state_next   = ST_DONE;
            illegal_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        work_next = work_shifted;
        rem_next  = rem_after;
        if (rem_after == '0) begin
          state_next  = ST_DONE;
          result_next = work_shifted;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign result  = result_q;
  assign busy    = (state == ST_RUN);
  assign done    = (state == ST_DONE);
  assign illegal = illegal_q;

endmodule
